// File: rtl/inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue
//   Dual-port instruction queue sitting between the instruction cache and the
//   dual-issue decoder. Accepts 0..2 {inst, pc} pairs per cycle from fetch and
//   presents the two oldest entries to decode, which consumes 0..2 of them.
//   A flush discards every buffered entry.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   resetn     : asynchronous active-low reset
//   flush      : synchronous discard of all entries (wins over push and pop)
//   push_en1/2 : write slot 1 / slot 2 (slot 2 only honoured with slot 1)
//   push_inst* : instruction words for the two write slots
//   push_pc*   : PCs for the two write slots
//   full       : fewer than two free entries; pushes are rejected while high
//   pop_en1/2  : decoder consumes out slot 1 / slot 2 (slot 2 needs slot 1)
//   out_valid* : out slot holds the oldest / second-oldest entry
//   out_inst*  : instruction words of the two oldest entries (0 when invalid)
//   out_pc*    : PCs of the two oldest entries (0 when invalid)
//   empty      : no entries buffered
// -----------------------------------------------------------------------------
module inst_fetch_queue #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        push_en1,
    input  logic        push_en2,
    input  logic [31:0] push_inst1,
    input  logic [31:0] push_inst2,
    input  logic [31:0] push_pc1,
    input  logic [31:0] push_pc2,
    output logic        full,
    input  logic        pop_en1,
    input  logic        pop_en2,
    output logic        out_valid1,
    output logic        out_valid2,
    output logic [31:0] out_inst1,
    output logic [31:0] out_inst2,
    output logic [31:0] out_pc1,
    output logic [31:0] out_pc2,
    output logic        empty
);

    localparam logic [PTR_W:0] FULL_THR = (PTR_W + 1)'(DEPTH - 2);

    // Clamp the requested pop count to the number of valid entries.
    function automatic logic [1:0] clamp_pop(input logic [1:0] req,
                                             input logic [PTR_W:0] cnt);
        logic [1:0] res;
        if (cnt < {{(PTR_W - 1){1'b0}}, req}) begin
            res = cnt[1:0];
        end else begin
            res = req;
        end
        return res;
    endfunction

    // Storage word layout: {inst[31:0], pc[31:0]}
    logic [63:0]      mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;

    logic [1:0]       np_s;
    logic [1:0]       nc_s;
    logic [1:0]       pop_req_s;
    logic             full_s;
    logic [PTR_W-1:0] wr_nxt_s;
    logic [PTR_W-1:0] rd_nxt_s;

    assign full_s   = (count_r > FULL_THR);
    assign wr_nxt_s = wr_ptr_r + PTR_W'(1);
    assign rd_nxt_s = rd_ptr_r + PTR_W'(1);

    // Push and pop counts for this cycle; flush and full gate them off.
    always_comb begin
        np_s      = 2'd0;
        nc_s      = 2'd0;
        pop_req_s = 2'd0;
        if (pop_en1 && pop_en2) begin
            pop_req_s = 2'd2;
        end else if (pop_en1) begin
            pop_req_s = 2'd1;
        end else begin
            pop_req_s = 2'd0;
        end
        if (flush || full_s) begin
            np_s = 2'd0;
        end else if (push_en1 && push_en2) begin
            np_s = 2'd2;
        end else if (push_en1) begin
            np_s = 2'd1;
        end else begin
            np_s = 2'd0;
        end
        if (flush) begin
            nc_s = 2'd0;
        end else begin
            nc_s = clamp_pop(pop_req_s, count_r);
        end
    end

    // Storage writes; contents are deliberately not reset or flushed.
    always_ff @(posedge clk) begin
        if (np_s != 2'd0) begin
            mem_r[wr_ptr_r] <= {push_inst1, push_pc1};
        end
        if (np_s == 2'd2) begin
            mem_r[wr_nxt_s] <= {push_inst2, push_pc2};
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(np_s);
            rd_ptr_r <= rd_ptr_r + PTR_W'(nc_s);
            count_r  <= count_r + (PTR_W + 1)'(np_s) - (PTR_W + 1)'(nc_s);
        end
    end

    assign full       = full_s;
    assign empty      = (count_r == '0);
    assign out_valid1 = (count_r != '0);
    assign out_valid2 = (count_r >= (PTR_W + 1)'(2));

    // Output slots read the two oldest entries, zeroed when not valid.
    always_comb begin
        out_inst1 = 32'h0;
        out_pc1   = 32'h0;
        out_inst2 = 32'h0;
        out_pc2   = 32'h0;
        if (out_valid1) begin
            out_inst1 = mem_r[rd_ptr_r][63:32];
            out_pc1   = mem_r[rd_ptr_r][31:0];
        end else begin
            out_inst1 = 32'h0;
            out_pc1   = 32'h0;
        end
        if (out_valid2) begin
            out_inst2 = mem_r[rd_nxt_s][63:32];
            out_pc2   = mem_r[rd_nxt_s][31:0];
        end else begin
            out_inst2 = 32'h0;
            out_pc2   = 32'h0;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;

    localparam int DEPTH = 16;
    localparam int PTR_W = 4;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic        push_en1, push_en2;
    logic [31:0] push_inst1, push_inst2, push_pc1, push_pc2;
    logic        full;
    logic        pop_en1, pop_en2;
    logic        out_valid1, out_valid2;
    logic [31:0] out_inst1, out_inst2, out_pc1, out_pc2;
    logic        empty;

    int checks = 0;
    int errors = 0;

    // Reference model: plain FIFO of {inst, pc}
    logic [63:0] mq[$];

    inst_fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .push_en1(push_en1), .push_en2(push_en2),
        .push_inst1(push_inst1), .push_inst2(push_inst2),
        .push_pc1(push_pc1), .push_pc2(push_pc2),
        .full(full),
        .pop_en1(pop_en1), .pop_en2(pop_en2),
        .out_valid1(out_valid1), .out_valid2(out_valid2),
        .out_inst1(out_inst1), .out_inst2(out_inst2),
        .out_pc1(out_pc1), .out_pc2(out_pc2),
        .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fl, p1, p2, o1, o2;
        logic [31:0] i1, c1, i2, c2;
        logic        ev1, ev2;
        logic [31:0] epc1, epc2;
        logic        efull, eempty;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Compare every output against the queue model.
    task automatic check_model(input string tag);
        int sz;
        logic [31:0] ei1, ep1, ei2, ep2;
        sz  = mq.size();
        ei1 = (sz >= 1) ? mq[0][63:32] : 32'h0;
        ep1 = (sz >= 1) ? mq[0][31:0]  : 32'h0;
        ei2 = (sz >= 2) ? mq[1][63:32] : 32'h0;
        ep2 = (sz >= 2) ? mq[1][31:0]  : 32'h0;
        chk({tag, ".valid1"}, {31'd0, out_valid1}, {31'd0, sz >= 1});
        chk({tag, ".valid2"}, {31'd0, out_valid2}, {31'd0, sz >= 2});
        chk({tag, ".inst1"}, out_inst1, ei1);
        chk({tag, ".pc1"}, out_pc1, ep1);
        chk({tag, ".inst2"}, out_inst2, ei2);
        chk({tag, ".pc2"}, out_pc2, ep2);
        chk({tag, ".full"}, {31'd0, full}, {31'd0, sz > DEPTH - 2});
        chk({tag, ".empty"}, {31'd0, empty}, {31'd0, sz == 0});
    endtask

    task automatic drive(input logic fl, input logic p1, input logic p2,
                         input logic [31:0] i1, input logic [31:0] c1,
                         input logic [31:0] i2, input logic [31:0] c2,
                         input logic o1, input logic o2);
        flush = fl; push_en1 = p1; push_en2 = p2;
        push_inst1 = i1; push_pc1 = c1; push_inst2 = i2; push_pc2 = c2;
        pop_en1 = o1; pop_en2 = o2;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    // One clock: apply the queue rules to the model, then check outputs.
    task automatic cycle(input string tag);
        int sz, req, nc;
        bit full_m;
        @(posedge clk);
        sz     = mq.size();
        full_m = (sz > DEPTH - 2);
        if (flush) begin
            mq.delete();
        end else begin
            req = pop_en1 ? (pop_en2 ? 2 : 1) : 0;
            nc  = (req < sz) ? req : sz;
            repeat (nc) void'(mq.pop_front());
            if (!full_m && push_en1) begin
                mq.push_back({push_inst1, push_pc1});
                if (push_en2) mq.push_back({push_inst2, push_pc2});
            end
        end
        #1;
        check_model(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".valid1"}, {31'd0, out_valid1}, 32'd0);
        chk({tag, ".valid2"}, {31'd0, out_valid2}, 32'd0);
        chk({tag, ".inst1"}, out_inst1, 32'h0);
        chk({tag, ".pc1"}, out_pc1, 32'h0);
        chk({tag, ".full"}, {31'd0, full}, 32'd0);
        chk({tag, ".empty"}, {31'd0, empty}, 32'd1);
    endtask

    initial begin
        logic [31:0] pc, prev;

        // Directed table (applied from empty right after reset)
        vecs[0] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0,32'h0,32'h0,
                    1'b0,1'b0, 32'h0,32'h0, 1'b0,1'b1};
        vecs[1] = '{1'b0,1'b1,1'b1,1'b0,1'b0, 32'h24020001,32'hBFC00000,32'h24030002,32'hBFC00004,
                    1'b1,1'b1, 32'hBFC00000,32'hBFC00004, 1'b0,1'b0};
        vecs[2] = '{1'b0,1'b0,1'b0,1'b1,1'b0, 32'h0,32'h0,32'h0,32'h0,
                    1'b1,1'b0, 32'hBFC00004,32'h0, 1'b0,1'b0};
        vecs[3] = '{1'b0,1'b1,1'b1,1'b1,1'b1, 32'h11110000,32'h00000100,32'h22220000,32'h00000104,
                    1'b1,1'b1, 32'h00000100,32'h00000104, 1'b0,1'b0};
        vecs[4] = '{1'b1,1'b1,1'b0,1'b0,1'b0, 32'h33330000,32'h00000200,32'h0,32'h0,
                    1'b0,1'b0, 32'h0,32'h0, 1'b0,1'b1};
        vecs[5] = '{1'b0,1'b1,1'b0,1'b0,1'b0, 32'h44440000,32'h00000300,32'h0,32'h0,
                    1'b1,1'b0, 32'h00000300,32'h0, 1'b0,1'b0};
        vecs[6] = '{1'b0,1'b0,1'b0,1'b1,1'b1, 32'h0,32'h0,32'h0,32'h0,
                    1'b0,1'b0, 32'h0,32'h0, 1'b0,1'b1};
        vecs[7] = '{1'b0,1'b0,1'b1,1'b0,1'b0, 32'h55550000,32'h00000400,32'h66660000,32'h00000404,
                    1'b0,1'b0, 32'h0,32'h0, 1'b0,1'b1};
        vecs[8] = '{1'b0,1'b0,1'b0,1'b1,1'b0, 32'h0,32'h0,32'h0,32'h0,
                    1'b0,1'b0, 32'h0,32'h0, 1'b0,1'b1};

        // Reset held for 3 cycles
        idle();
        resetn = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check_reset_outputs("reset");
        end
        resetn = 1'b1;
        mq.delete();
        cycle("post_reset");

        // Table-driven vectors
        for (int k = 0; k < 9; k++) begin
            drive(vecs[k].fl, vecs[k].p1, vecs[k].p2, vecs[k].i1, vecs[k].c1,
                  vecs[k].i2, vecs[k].c2, vecs[k].o1, vecs[k].o2);
            cycle($sformatf("vec%0d", k));
            chk($sformatf("vec%0d.tvalid1", k), {31'd0, out_valid1}, {31'd0, vecs[k].ev1});
            chk($sformatf("vec%0d.tvalid2", k), {31'd0, out_valid2}, {31'd0, vecs[k].ev2});
            chk($sformatf("vec%0d.tpc1", k), out_pc1, vecs[k].epc1);
            chk($sformatf("vec%0d.tpc2", k), out_pc2, vecs[k].epc2);
            chk($sformatf("vec%0d.tfull", k), {31'd0, full}, {31'd0, vecs[k].efull});
            chk($sformatf("vec%0d.tempty", k), {31'd0, empty}, {31'd0, vecs[k].eempty});
        end
        chk("vec1.inst1", 32'h0, out_inst1); // queue is empty after vec8

        // Fill to full: 8 dual pushes, 9th dropped, then pop two
        pc = 32'h00002000;
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 1'b1, 1'b1, pc ^ 32'hA5A50000, pc, (pc + 32'd4) ^ 32'hA5A50000, pc + 32'd4, 1'b0, 1'b0);
            pc = pc + 32'd8;
            cycle("fill");
            chk("fill.full", {31'd0, full}, (k == 7) ? 32'd1 : 32'd0);
        end
        drive(1'b0, 1'b1, 1'b1, 32'hDEAD0001, 32'h0000DEAD, 32'hDEAD0002, 32'h0000DEB1, 1'b0, 1'b0);
        cycle("push_when_full");
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
        cycle("pop_to_14");
        chk("pop_to_14.full", {31'd0, full}, 32'd0);
        chk("pop_to_14.pc1", out_pc1, 32'h00002008);
        drive(1'b0, 1'b1, 1'b0, 32'hBEEF0000, 32'h0000BEEF, 32'h0, 32'h0, 1'b0, 1'b0);
        cycle("push_to_15");
        chk("push_to_15.full", {31'd0, full}, 32'd1);
        // full at 15: push rejected even with a pop this cycle
        drive(1'b0, 1'b1, 1'b0, 32'hBAD00000, 32'h0000BAD0, 32'h0, 32'h0, 1'b1, 1'b0);
        cycle("push_pop_at_15");
        chk("push_pop_at_15.full", {31'd0, full}, 32'd0);
        idle();
        for (int k = 0; k < 8; k++) begin
            pop_en1 = 1'b1; pop_en2 = 1'b1;
            cycle("drain");
        end
        chk("drain.empty", {31'd0, empty}, 32'd1);

        // Wrap-around with an odd pointer so pairs straddle index 15/0
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        cycle("wrap_flush");
        pc = 32'h00001000;
        drive(1'b0, 1'b1, 1'b1, ~pc, pc, ~(pc + 32'd4), pc + 32'd4, 1'b0, 1'b0);
        cycle("wrap_pre2");
        pc = pc + 32'd8;
        drive(1'b0, 1'b1, 1'b0, ~pc, pc, 32'h0, 32'h0, 1'b0, 1'b0);
        cycle("wrap_pre1");
        pc = pc + 32'd4;
        prev = out_pc1;
        chk("wrap.start", prev, 32'h00001000);
        for (int k = 0; k < 20; k++) begin
            drive(1'b0, 1'b1, 1'b1, ~pc, pc, ~(pc + 32'd4), pc + 32'd4, 1'b1, 1'b1);
            pc = pc + 32'd8;
            cycle("wrap");
            chk("wrap.step", out_pc1, prev + 32'd8);
            chk("wrap.valid2", {31'd0, out_valid2}, 32'd1);
            prev = out_pc1;
        end

        // Flush at count 5 with a simultaneous push, then push after flush
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        cycle("fl5_clear");
        drive(1'b0, 1'b1, 1'b1, 32'h1, 32'h3000, 32'h2, 32'h3004, 1'b0, 1'b0);
        cycle("fl5_a");
        drive(1'b0, 1'b1, 1'b1, 32'h3, 32'h3008, 32'h4, 32'h300C, 1'b0, 1'b0);
        cycle("fl5_b");
        drive(1'b0, 1'b1, 1'b0, 32'h5, 32'h3010, 32'h0, 32'h0, 1'b0, 1'b0);
        cycle("fl5_c");
        drive(1'b1, 1'b1, 1'b0, 32'h6, 32'h3014, 32'h0, 32'h0, 1'b0, 1'b0);
        cycle("fl5_flush");
        chk("fl5_flush.empty", {31'd0, empty}, 32'd1);
        chk("fl5_flush.valid1", {31'd0, out_valid1}, 32'd0);
        drive(1'b0, 1'b1, 1'b0, 32'h7, 32'h3018, 32'h0, 32'h0, 1'b0, 1'b0);
        cycle("after_flush");
        chk("after_flush.pc1", out_pc1, 32'h3018);
        chk("after_flush.inst1", out_inst1, 32'h7);

        // Asynchronous reset mid-cycle
        drive(1'b0, 1'b1, 1'b1, 32'h8, 32'h301C, 32'h9, 32'h3020, 1'b0, 1'b0);
        cycle("pre_async");
        idle();
        #2;
        resetn = 1'b0;
        #1;
        mq.delete();
        check_reset_outputs("async_reset");
        @(posedge clk);
        #1;
        resetn = 1'b1;
        cycle("async_release");

        // Randomized traffic against the queue model
        for (int k = 0; k < 3000; k++) begin
            drive(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom, $urandom, $urandom, $urandom,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1);
            cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Dual-port instruction queue between the instruction cache and decode. Each cycle it accepts 0, 1 or 2 instruction/PC pairs from the fetch side (the cache's data_ok1/data_ok2 beats) and presents the two oldest entries to the dual-issue decoder, which may consume 0, 1 or 2 of them. It decouples cache latency and line-end single-word returns from issue width. It also discards all buffered instructions on a pipeline flush.

## Interface

Parameters:
- DEPTH, 16: number of entries; must be a power of two and at least 4.
- PTR_W, 4: pointer width, equal to log2(DEPTH).

Ports:
- clk, input, 1: clock. All state updates on the rising edge.
- resetn, input, 1: reset. Asynchronous, active-low.
- flush, input, 1: synchronous discard of all entries.
- push_en1, input, 1: write slot 1 this cycle.
- push_en2, input, 1: write slot 2 this cycle. Only legal together with push_en1.
- push_inst1, input, 32: instruction word for slot 1.
- push_inst2, input, 32: instruction word for slot 2.
- push_pc1, input, 32: PC of push_inst1.
- push_pc2, input, 32: PC of push_inst2, normally push_pc1+4.
- full, output, 1: fewer than 2 free entries. Fetch must not push while this is high.
- pop_en1, input, 1: decoder consumes out slot 1.
- pop_en2, input, 1: decoder consumes out slot 2. Only legal together with pop_en1.
- out_valid1, output, 1: out slot 1 holds the oldest entry.
- out_valid2, output, 1: out slot 2 holds the second-oldest entry.
- out_inst1, output, 32: instruction word of the oldest entry.
- out_inst2, output, 32: instruction word of the second-oldest entry.
- out_pc1, output, 32: PC of the oldest entry.
- out_pc2, output, 32: PC of the second-oldest entry.
- empty, output, 1: count == 0.

## Operation

- State:
  - storage array of DEPTH × {inst[31:0], pc[31:0]};
  - wr_ptr and rd_ptr, each PTR_W bits, wrapping modulo DEPTH;
  - count, PTR_W+1 bits, range 0..DEPTH.
- Push count np:
  - np = 0 if full or flush.
  - Otherwise np = push_en1 + (push_en1 & push_en2).
  - push_en2 without push_en1 is ignored.
- Push writes:
  - Slot 1 is written at wr_ptr, slot 2 at wr_ptr+1 (wrapping).
  - wr_ptr advances by np.
- Pop count nc:
  - nc = 0 if flush.
  - Otherwise nc = min(pop_en1 + (pop_en1 & pop_en2), count).
  - Pops beyond the valid count are ignored.
  - rd_ptr advances by nc.
- Count update: count_next = count + np − nc. Simultaneous push and pop are both honoured.
- full is computed combinationally from the registered count: full = (count > DEPTH−2).
  - A push is rejected whenever full is high, even if a pop occurs in the same cycle.
- Flush has priority over push and pop. It sets wr_ptr = rd_ptr = 0 and count = 0. Storage contents are left unchanged.
- Output validity: out_valid1 = (count ≥ 1), out_valid2 = (count ≥ 2).
- Output data:
  - Slot 1 reads storage[rd_ptr]; slot 2 reads storage[rd_ptr+1], wrapping.
  - Data outputs of an invalid slot are forced to 32'h0.
- There is no bypass: an entry is never visible at the outputs in the cycle it is pushed.
- Order is strictly FIFO. Slot 1 of a push is older than slot 2.

## Timing

- Reset (resetn low, asynchronous), held until resetn deasserts:
  - wr_ptr = 0, rd_ptr = 0, count = 0;
  - out_valid1 = out_valid2 = 0;
  - all out_inst and out_pc outputs = 0;
  - full = 0, empty = 1.
- Reset asserted mid-operation takes effect immediately, without waiting for a clock edge. The queue restarts empty on the first edge after deassertion.
- Latency: a push accepted at edge N appears on the outputs after edge N (cycle N+1) when it is the oldest entry. Minimum push-to-pop latency is one cycle.
- full, empty, out_valid* and out_* are combinational from registers only. No input reaches any output in the same cycle.
- Wrap-around: pointer arithmetic is modulo DEPTH. A two-entry push or pop straddling index DEPTH−1/0 is legal and preserves order.
- Boundaries:
  - count = DEPTH−2: full = 0, so a two-entry push is accepted and count becomes DEPTH.
  - count = DEPTH−1 or DEPTH: full = 1.
  - count = 1: pop_en1 & pop_en2 consumes one entry only.
  - Flush and push in the same cycle: the push is dropped, and the queue is empty next cycle.

## Test plan

- Reset then idle:
  - Stimulus: resetn low for 3 cycles, then high.
  - Response: empty=1, full=0, out_valid1/2=0, out_inst1=0 throughout.
- Dual push then single pops:
  - Stimulus: push {0x24020001 @0xBFC00000, 0x24030002 @0xBFC00004} in one cycle.
  - Response next cycle: out_valid1=out_valid2=1, out_pc1=0xBFC00000, out_pc2=0xBFC00004.
  - Stimulus: pop_en1 only.
  - Response next cycle: out_pc1=0xBFC00004, out_valid2=0.
- Fill to full:
  - Stimulus: 8 dual pushes with DEPTH=16.
  - Response: full rises when count reaches 15/16. A 9th push is dropped and count stays 16.
  - Stimulus: pop two.
  - Response: count=14, full=0.
- Wrap-around:
  - Stimulus: interleave push-2/pop-2 for 20 cycles with PCs incrementing by 4.
  - Response: out_pc1 sequence is strictly +8 per pop-2 across the pointer wrap, and count stays constant.
- Simultaneous events:
  - Stimulus: count=1, then pop_en1&pop_en2 together with a dual push.
  - Response: count=2 next cycle, and out_pc1 is the first newly pushed PC.
- Flush:
  - Stimulus: count=5, then flush with push_en1=1 in the same cycle.
  - Response: next cycle empty=1, out_valid1=0.
  - Stimulus: push after flush.
  - Response: the pushed entry appears one cycle later.
